// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU register read path.
package ppu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } rd_state_e;

  localparam int unsigned      PPU_VRAM_ADDR_W     = 14;
  localparam logic [5:0]       PALETTE_PAGE        = 6'h3F;
  localparam logic [13:0]      PALETTE_MIRROR_MASK = 14'h2FFF;

endpackage

// File: rtl/ppu_rd_watchdog.sv
// Cycle counter for a pending VRAM read; expired flags the Limit-th enabled cycle.
module ppu_rd_watchdog #(
  parameter int unsigned Limit = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = en && (count_q == CntW'(Limit - 1));

endmodule

// File: rtl/ppu_reg_data_read.sv
// CPU read path of PPUDATA: returns the read buffer (or palette) and refills it from VRAM.
// Optional watchdog on the VRAM request is enabled by defining PPU_RD_TIMEOUT_EN.
module ppu_reg_data_read
  import ppu_pkg::*;
#(
  parameter int unsigned ADDR_W         = PPU_VRAM_ADDR_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_read_en,
  input  logic [15:0]       address_in,
  input  logic [7:0]        pal_rd_data,
  output logic [7:0]        cpu_data_out,
  output logic              cpu_data_valid,
  output logic              vram_rd_req,
  output logic [ADDR_W-1:0] vram_rd_addr,
  input  logic              vram_rd_ack,
  input  logic [7:0]        vram_rd_data,
  output logic              reg_data_read_completed,
  output logic              busy,
  output logic              rd_timeout
);

  rd_state_e         state_q, state_d;
  logic [7:0]        buf_q, buf_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              comp_q, comp_d;
  logic              timeout_hit;

  logic [ADDR_W-1:0] rd_addr;
  logic              accept;
  logic              unused_addr_hi;

  // Upper address bits are dropped so the VRAM space mirrors at 0x4000.
  assign rd_addr        = address_in[ADDR_W-1:0];
  assign unused_addr_hi = ^address_in[15:ADDR_W];
  assign accept         = (state_q == StIdle) && data_read_en;

`ifdef PPU_RD_TIMEOUT_EN
  logic wd_expired;
  logic timeout_q;

  ppu_rd_watchdog #(
    .Limit (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      ((state_q == StReq) && !vram_rd_ack),
    .expired (wd_expired)
  );

  assign timeout_hit = wd_expired;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign rd_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rd_timeout  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    data_d  = data_q;
    valid_d = 1'b0;
    req_d   = req_q;
    addr_d  = addr_q;
    comp_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Palette reads bypass the buffer; the buffer refills from the nametable underneath.
          if (rd_addr[13:8] == PALETTE_PAGE) begin
            data_d = pal_rd_data;
            addr_d = rd_addr & ADDR_W'(PALETTE_MIRROR_MASK);
          end else begin
            data_d = buf_q;
            addr_d = rd_addr;
          end
          valid_d = 1'b1;
          req_d   = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (vram_rd_ack) begin
          buf_d   = vram_rd_data;
          req_d   = 1'b0;
          comp_d  = 1'b1;
          state_d = StDone;
        end else if (timeout_hit) begin
          buf_d   = 8'h00;
          req_d   = 1'b0;
          comp_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      comp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      comp_q  <= comp_d;
    end
  end

  assign cpu_data_out            = data_q;
  assign cpu_data_valid          = valid_q;
  assign vram_rd_req             = req_q;
  assign vram_rd_addr            = addr_q;
  assign reg_data_read_completed = comp_q;
  assign busy                    = (state_q != StIdle);

endmodule

// File: tb/tb_ppu_reg_data_read.sv
// Scoreboard bench for ppu_reg_data_read with a read-buffer reference model.
module tb_ppu_reg_data_read;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_read_en;
  logic [15:0] address_in;
  logic [7:0]  pal_rd_data;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_valid;
  logic        vram_rd_req;
  logic [13:0] vram_rd_addr;
  logic        vram_rd_ack;
  logic [7:0]  vram_rd_data;
  logic        reg_data_read_completed;
  logic        busy;
  logic        rd_timeout;

  always #5 clk = ~clk;

  ppu_reg_data_read dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .data_read_en            (data_read_en),
    .address_in              (address_in),
    .pal_rd_data             (pal_rd_data),
    .cpu_data_out            (cpu_data_out),
    .cpu_data_valid          (cpu_data_valid),
    .vram_rd_req             (vram_rd_req),
    .vram_rd_addr            (vram_rd_addr),
    .vram_rd_ack             (vram_rd_ack),
    .vram_rd_data            (vram_rd_data),
    .reg_data_read_completed (reg_data_read_completed),
    .busy                    (busy),
    .rd_timeout              (rd_timeout)
  );

  typedef struct {
    logic [7:0]  data;
    logic [13:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned comp_exp    = 0;
  int unsigned comp_seen   = 0;
  logic [7:0]  model_buf   = 8'h00;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  // Reference: 14-bit VRAM space; palette page reads return palette data and the
  // VRAM fetch goes 0x1000 lower (into the nametable mirror).
  function automatic exp_t predict(logic [15:0] addr, logic [7:0] pal);
    exp_t e;
    int unsigned a;
    a = addr % 16384;
    if (a >= 'h3F00) begin
      e.data = pal;
      e.addr = 14'(a - 'h1000);
    end else begin
      e.data = model_buf;
      e.addr = 14'(a);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && cpu_data_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("cpu_data", cpu_data_out, e.data);
        check("rd_addr_at_valid", vram_rd_addr, e.addr);
      end
    end
    if (rst_n && reg_data_read_completed) comp_seen++;
  end

  // Issue one strobe and return with the expected addr; the DUT is then in REQ.
  task automatic strobe(input logic [15:0] addr, input logic [7:0] pal, output logic [13:0] eaddr);
    exp_t e;
    @(negedge clk);
    e = predict(addr, pal);
    exp_q.push_back(e);
    eaddr        = e.addr;
    data_read_en = 1'b1;
    address_in   = addr;
    pal_rd_data  = pal;
    @(negedge clk);
    data_read_en = 1'b0;
    address_in   = 16'($urandom);
    pal_rd_data  = 8'($urandom);
    check("req_raised", vram_rd_req, 1'b1);
    check("busy_in_req", busy, 1'b1);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] pal, input logic [7:0] vdata,
                         input int delay, input bit strobe_req, input bit strobe_done);
    logic [13:0] eaddr;
    strobe(addr, pal, eaddr);
    for (int i = 0; i < delay; i++) begin
      data_read_en = strobe_req && (i == 0);
      @(negedge clk);
      data_read_en = 1'b0;
      check("req_held", vram_rd_req, 1'b1);
      check("addr_held", vram_rd_addr, eaddr);
      check("no_early_comp", reg_data_read_completed, 1'b0);
    end
    vram_rd_ack  = 1'b1;
    vram_rd_data = vdata;
    data_read_en = strobe_req && (delay == 0);
    @(negedge clk);
    vram_rd_ack  = 1'b0;
    vram_rd_data = 8'($urandom);
    data_read_en = strobe_done;
    model_buf    = vdata;
    comp_exp++;
    check("comp_pulse", reg_data_read_completed, 1'b1);
    check("req_dropped", vram_rd_req, 1'b0);
    check("busy_in_done", busy, 1'b1);
    @(negedge clk);
    data_read_en = 1'b0;
    check("comp_single", reg_data_read_completed, 1'b0);
    check("idle_after", busy, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    model_buf = 8'h00;
    check("rst_req", vram_rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", cpu_data_out, 8'h00);
    check("rst_valid", cpu_data_valid, 1'b0);
    check("rst_comp", reg_data_read_completed, 1'b0);
    check("rst_addr", vram_rd_addr, 14'h0);
  endtask

  initial begin
    logic [13:0] ea;
    rst_n        = 1'b1;
    data_read_en = 1'b0;
    address_in   = 16'h0;
    pal_rd_data  = 8'h0;
    vram_rd_ack  = 1'b0;
    vram_rd_data = 8'h0;

    do_reset();
    check("rst_timeout", rd_timeout, 1'b0);

    // Buffered reads: first returns stale 0, second returns A5.
    do_read(16'h2000, 8'h00, 8'hA5, 0, 1'b0, 1'b0);
    do_read(16'h2001, 8'h00, 8'h3C, 0, 1'b0, 1'b0);
    // Palette read then a buffered read returning the refill.
    do_read(16'h3F05, 8'h1C, 8'h77, 1, 1'b0, 1'b0);
    do_read(16'h2002, 8'h00, 8'h10, 0, 1'b0, 1'b0);
    // Delayed ack.
    do_read(16'h2400, 8'h00, 8'h21, 5, 1'b0, 1'b0);
    // Dropped strobes in REQ and DONE, and coincident with ack.
    do_read(16'h2100, 8'h00, 8'h5A, 2, 1'b1, 1'b1);
    do_read(16'h2101, 8'h00, 8'h66, 0, 1'b1, 1'b1);
    // Mirror at 0x4000.
    do_read(16'h7ABC, 8'h00, 8'h99, 1, 1'b0, 1'b0);

    // Reset during REQ abandons the request and clears the buffer.
    strobe(16'h2222, 8'h00, ea);
    do_reset();
    do_read(16'h2003, 8'h00, 8'h42, 0, 1'b0, 1'b0);

`ifdef PPU_RD_TIMEOUT_EN
    strobe(16'h2500, 8'h00, ea);
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      check("wd_req_held", vram_rd_req, 1'b1);
    end
    @(negedge clk);
    comp_exp++;
    model_buf = 8'h00;
    check("wd_req_drop", vram_rd_req, 1'b0);
    check("wd_comp", reg_data_read_completed, 1'b1);
    check("wd_flag", rd_timeout, 1'b1);
    @(negedge clk);
    check("wd_idle", busy, 1'b0);
    do_read(16'h2004, 8'h00, 8'h13, 0, 1'b0, 1'b0);
`else
    do_read(16'h2500, 8'h00, 8'h13, 20, 1'b0, 1'b0);
    check("no_timeout", rd_timeout, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(3) == 0) a[13:8] = 6'h3F;
      do_read(a, 8'($urandom), 8'($urandom), int'($urandom_range(6)),
              1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (3) @(negedge clk);
    check("completions", comp_seen, comp_exp);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ppu_reg_data_read.md
Name: ppu_reg_data_read

Overview:
- CPU read path of the PPU DATA register (0x2007), the reader counterpart to the address/data write path.
- On each CPU read it returns the internal read buffer and then issues a VRAM read at the current VRAM address to refill the buffer.
- When the refill completes it pulses an increment request back to the address register.
- Palette addresses (0x3F00-0x3FFF) return palette data immediately; the buffer is refilled from the nametable mirror underneath.

Parameters:
- ADDR_W, 14: effective VRAM address width; input address is masked to this width.
- TIMEOUT_CYCLES, 16: watchdog limit in clk cycles; used only with PPU_RD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- data_read_en  in  1  one-cycle strobe: CPU read of 0x2007
- address_in  in  16  current VRAM address from the address register
- pal_rd_data  in  8  palette RAM data; combinational, indexed externally by address_in[4:0]
- cpu_data_out  out  8  data returned to CPU
- cpu_data_valid  out  1  one-cycle pulse qualifying cpu_data_out
- vram_rd_req  out  1  VRAM read request, level
- vram_rd_addr  out  ADDR_W  VRAM read address
- vram_rd_ack  in  1  VRAM read acknowledge; vram_rd_data is valid in the same cycle
- vram_rd_data  in  8  VRAM read data
- reg_data_read_completed  out  1  one-cycle pulse requesting address increment (+1 or +32, applied by the address register)
- busy  out  1  high whenever state is not IDLE
- rd_timeout  out  1  sticky watchdog flag; tied 0 without the macro

Behaviour:
- Reset (rst_n=0 at posedge clk): state=IDLE; read buffer=8'h00; cpu_data_out=8'h00; all strobes, vram_rd_req, busy and rd_timeout=0; vram_rd_addr=0. Reset mid-transaction abandons the request; vram_rd_req drops on the next edge.
- States: IDLE, REQ, DONE.
- IDLE, data_read_en=1:
  - Capture a = address_in[ADDR_W-1:0]. Bits above ADDR_W are ignored, so the address mirrors at 0x4000.
  - If a[13:8]==6'h3F (palette): cpu_data_out<=pal_rd_data; vram_rd_addr<=a & 14'h2FFF.
  - Otherwise: cpu_data_out<=buffer; vram_rd_addr<=a.
  - cpu_data_valid<=1 for one cycle; vram_rd_req<=1; go to REQ.
  - CPU data latency is 1 cycle after the strobe.
- REQ:
  - vram_rd_req and vram_rd_addr are held stable until vram_rd_ack is sampled high.
  - On ack: buffer<=vram_rd_data; vram_rd_req<=0; reg_data_read_completed<=1; go to DONE.
- DONE: completed pulse is high for this single cycle; go to IDLE.
- Minimum strobe-to-completed latency is 2 cycles (ack on the first REQ cycle).
- data_read_en while not in IDLE (REQ or DONE): the strobe is dropped. No cpu_data_valid, no state change, buffer untouched.
- data_read_en coincident with vram_rd_ack in REQ: the ack is processed and the strobe is dropped.
- vram_rd_ack outside REQ: ignored.
- Address capture at the strobe isolates the in-flight request from the address register incrementing after the completed pulse.
- This block never writes VRAM or palette.

Optional Feature:
- Macro PPU_RD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: buffer<=8'h00, vram_rd_req<=0, rd_timeout<=1, go to DONE. reg_data_read_completed still pulses, so the address still advances.
  - rd_timeout clears only on reset.
- Not defined: no counter; REQ waits indefinitely; rd_timeout is constant 0.

Decomposition:
- Shared package ppu_pkg holds:
  - the state enum typedef (IDLE/REQ/DONE);
  - PPU_VRAM_ADDR_W=14;
  - PALETTE_PAGE=6'h3F;
  - PALETTE_MIRROR_MASK=14'h2FFF.
- One natural sub-module, ppu_rd_watchdog: counter with clear/enable inputs and an expired output, instantiated only under PPU_RD_TIMEOUT_EN.

Test Plan:
- Buffered read: reset, then strobe with address_in=16'h2000 and ack next cycle with vram_rd_data=8'hA5 -> cpu_data_out=8'h00 (stale); completed pulses.
  - Second strobe at 16'h2001 -> cpu_data_out=8'hA5.
- Palette read: strobe at 16'h3F05, pal_rd_data=8'h1C -> cpu_data_out=8'h1C next cycle; vram_rd_addr=14'h2F05.
  - Ack data 8'h77 loads the buffer; the next non-palette read returns 8'h77.
- Delayed ack: ack held off 5 cycles -> vram_rd_req and vram_rd_addr stay stable for all 5; busy=1; exactly one completed pulse, on the cycle after ack.
- Dropped strobe: second data_read_en during REQ, and another during DONE -> single cpu_data_valid and single completed pulse; buffer reflects only the first request.
- Mirror/reset: strobe at 16'h7ABC -> vram_rd_addr=14'h3ABC. Assert rst_n=0 during REQ -> next cycle state IDLE, vram_rd_req=0, buffer=8'h00.
- Timeout (PPU_RD_TIMEOUT_EN): no ack for 16 REQ cycles -> vram_rd_req drops, rd_timeout=1, completed pulses once, buffer=8'h00. Without the macro, the same stimulus leaves vram_rd_req=1 indefinitely.
